// File: rtl/bit_selection_rd_port.sv
// Read-port bit selection: extracts and right-aligns a narrow field from the RAM read word.
// Define BIT_SELECTION_RD_OUTREG_EN to add a third output register stage.
module bit_selection_rd_port #(
  parameter logic [2:0] CONFIG_1BIT  = 3'd1,
  parameter logic [2:0] CONFIG_2BIT  = 3'd2,
  parameter logic [2:0] CONFIG_5BIT  = 3'd3,
  parameter logic [2:0] CONFIG_10BIT = 3'd4,
  parameter logic [2:0] CONFIG_20BIT = 3'd5,
  parameter logic [2:0] CONFIG_40BIT = 3'd6,
  parameter logic [2:0] CONFIG_80BIT = 3'd7
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        bist_active_i,
  input  logic [2:0]  output_config_i,
  input  logic        en_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [15:0] addr_i,
  input  logic [19:0] rdata_i,
  output logic [19:0] data_o,
  output logic        rvalid_o
);

  logic        req;
  logic        v1;
  logic [4:0]  addr1;
  logic [2:0]  cfg1;
  logic        bist1;
  logic [4:0]  bit_idx;
  logic [4:0]  pair_lo;
  logic [4:0]  seg_lo;
  logic [19:0] extracted;
  logic [19:0] data2;
  logic        valid2;
  logic        unused;

  assign req    = en_i & re_i & ~we_i;
  assign unused = ^{addr_i[15:5], addr1[0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1    <= 1'b0;
      addr1 <= '0;
      cfg1  <= '0;
      bist1 <= 1'b0;
    end else begin
      v1 <= req;
      if (req) begin
        addr1 <= addr_i[4:0];
        cfg1  <= output_config_i;
        bist1 <= bist_active_i;
      end
    end
  end

  // Every fifth RAM bit is skipped in narrow modes, hence the k + k/4 style offsets.
  assign bit_idx = {1'b0, addr1[4:1]} + {3'b000, addr1[4:3]};
  assign pair_lo = {1'b0, addr1[4:2], 1'b0} + {3'b000, addr1[4:3]};
  assign seg_lo  = {1'b0, addr1[4:3], 2'b00} + {3'b000, addr1[4:3]};

  always_comb begin
    extracted = '0;
    if (bist1) begin
      extracted = rdata_i;
    end else begin
      case (cfg1)
        CONFIG_1BIT:  extracted[0]   = rdata_i[bit_idx];
        CONFIG_2BIT:  extracted[1:0] = rdata_i[pair_lo +: 2];
        CONFIG_5BIT:  extracted[4:0] = rdata_i[seg_lo +: 5];
        CONFIG_10BIT: extracted[9:0] = addr1[4] ? rdata_i[19:10] : rdata_i[9:0];
        CONFIG_20BIT, CONFIG_40BIT, CONFIG_80BIT: extracted = rdata_i;
        default:      extracted = rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data2  <= '0;
      valid2 <= 1'b0;
    end else begin
      valid2 <= v1;
      if (v1) data2 <= extracted;
    end
  end

`ifdef BIT_SELECTION_RD_OUTREG_EN
  logic [19:0] data3;
  logic        valid3;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data3  <= '0;
      valid3 <= 1'b0;
    end else begin
      data3  <= data2;
      valid3 <= valid2;
    end
  end

  assign data_o   = data3;
  assign rvalid_o = valid3;
`else
  assign data_o   = data2;
  assign rvalid_o = valid2;
`endif

endmodule

// File: tb/tb_bit_selection_rd_port.sv
// Randomized plus directed bench for bit_selection_rd_port against a table-driven reference model.
// Honours BIT_SELECTION_RD_OUTREG_EN for the extra output stage.
module tb_bit_selection_rd_port;

`ifdef BIT_SELECTION_RD_OUTREG_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        bist;
  logic [2:0]  cfg;
  logic        en, we, re;
  logic [15:0] addr;
  logic [19:0] rdata;
  logic [19:0] data;
  logic        rvalid;

  bit_selection_rd_port dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .bist_active_i   (bist),
    .output_config_i (cfg),
    .en_i            (en),
    .we_i            (we),
    .re_i            (re),
    .addr_i          (addr),
    .rdata_i         (rdata),
    .data_o          (data),
    .rvalid_o        (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [19:0] d;
  } exp_t;

  int one_pos [16] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11, 12, 13, 15, 16, 17, 18};
  int pair_pos [8] = '{0, 2, 5, 7, 10, 12, 15, 17};

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [19:0] md;
  logic        pend_v;
  logic [2:0]  pend_cfg;
  logic [4:0]  pend_addr;
  logic        pend_bist;

  task automatic check_eq(input string tag, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_extract(input logic [2:0] c, input logic [4:0] a,
                                              input logic b, input logic [19:0] rd);
    if (b) return rd;
    case (c)
      3'd1: return (rd >> one_pos[a[4:1]]) & 20'h00001;
      3'd2: return (rd >> pair_pos[a[4:2]]) & 20'h00003;
      3'd3: return (rd >> (5 * a[4:3])) & 20'h0001F;
      3'd4: return (rd >> (10 * a[4])) & 20'h003FF;
      default: return rd;
    endcase
  endfunction

  task automatic model_reset();
    exp_t z;
    z.v = 1'b0;
    z.d = '0;
    exp_q.delete();
    for (int i = 0; i < DLY; i++) exp_q.push_back(z);
    md     = '0;
    pend_v = 1'b0;
  endtask

  // One clock: check outputs, drive this cycle's request plus read data for the previous one.
  task automatic do_cycle(input logic e, input logic w, input logic r, input logic [2:0] c,
                          input logic [15:0] a, input logic b, input logic [19:0] rd,
                          input logic rst_pulse);
    exp_t ex;
    @(posedge clk);
    #1;
    if (exp_q.size() > DLY) begin
      ex = exp_q.pop_front();
      check_eq("rvalid", {19'b0, rvalid}, {19'b0, ex.v});
      check_eq("data", data, ex.d);
    end
    en = e; we = w; re = r; cfg = c; addr = a; bist = b; rdata = rd;
    if (pend_v) md = ref_extract(pend_cfg, pend_addr, pend_bist, rd);
    ex.v = pend_v;
    ex.d = md;
    if (rst_pulse) begin
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_data", data, 20'h0);
      check_eq("rst_rvalid", {19'b0, rvalid}, 20'h0);
      #3 rst_n = 1'b1;
      model_reset();
      ex.v = 1'b0;
      ex.d = '0;
    end
    pend_v    = e & r & ~w;
    pend_cfg  = c;
    pend_addr = a[4:0];
    pend_bist = b;
    exp_q.push_back(ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 20'h0, 1'b0);
  endtask

  task automatic rd_req(input logic [2:0] c, input logic [15:0] a, input logic b, input logic [19:0] prev_rd);
    do_cycle(1'b1, 1'b0, 1'b1, c, a, b, prev_rd, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; we = 1'b0; re = 1'b0;
    cfg = '0; addr = '0; bist = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_data", data, 20'h0);
    check_eq("reset_rvalid", {19'b0, rvalid}, 20'h0);
    rst_n = 1'b1;
    model_reset();

    // 1-bit mode, k=15 then k=4
    rd_req(3'd1, 16'h001E, 1'b0, 20'h0);
    rd_req(3'd1, 16'h0008, 1'b0, 20'h40000);
    do_cycle(1'b0, 1'b0, 1'b0, 3'd1, 16'h0, 1'b0, 20'h00020, 1'b0);
    idle(DLY + 2);
    check_eq("s1_hold", data, 20'h00001);

    // 5-bit then 10-bit
    rd_req(3'd3, 16'h0010, 1'b0, 20'h0);
    rd_req(3'd4, 16'h0010, 1'b0, 20'h07C00);
    do_cycle(1'b0, 1'b0, 1'b0, 3'd5, 16'hFFFF, 1'b0, 20'hABCDE, 1'b0);
    idle(DLY + 2);
    check_eq("s2_hold", data, 20'h002AF);

    // back-to-back 2-bit reads, config then forced to 5
    rd_req(3'd2, 16'h0000, 1'b0, 20'h0);
    rd_req(3'd2, 16'h0004, 1'b0, 20'hFFFFF);
    rd_req(3'd2, 16'h0018, 1'b0, 20'hFFFFF);
    rd_req(3'd2, 16'h001C, 1'b0, 20'hFFFFF);
    do_cycle(1'b0, 1'b0, 1'b0, 3'd5, 16'h0000, 1'b0, 20'hFFFFF, 1'b0);
    idle(DLY + 2);
    check_eq("s3_hold", data, 20'h00003);

    // write blocks read; BIST bypass
    do_cycle(1'b1, 1'b1, 1'b1, 3'd1, 16'h0002, 1'b0, 20'h0, 1'b0);
    rd_req(3'd1, 16'h0002, 1'b1, 20'hFFFFF);
    do_cycle(1'b0, 1'b0, 1'b0, 3'd1, 16'h0, 1'b0, 20'h5A5A5, 1'b0);
    idle(DLY + 2);
    check_eq("s4_hold", data, 20'h5A5A5);

    // reset mid-flight
    rd_req(3'd1, 16'h001E, 1'b0, 20'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 3'd1, 16'h0, 1'b0, 20'h40000, 1'b1);
    idle(DLY + 3);
    check_eq("s5_data", data, 20'h0);

    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
               3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 9) == 0,
               20'($urandom), $urandom_range(0, 99) == 0);
    end
    idle(DLY + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
